seq_shift_rotate_unit: RTL and testbench

SEQ_SHIFT_ROTATE_UNIT -- requirements
Module: seq_shift_rotate_unit

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_step.sv | 38 +++
 rtl/seq_shift_rotate_unit.sv | 108 ++++++++++
 tb/tb_seq_shift_rotate_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift/rotate unit: operation codes
// and the controller state encoding.
package shift_pkg;

   typedef enum logic [2:0] {
      OP_SHR  = 3'b000,
      OP_SHRA = 3'b001,
      OP_SHL  = 3'b010,
      OP_ROR  = 3'b011,
      OP_ROL  = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/shift_step.sv
// One cycle's worth of shifting: applies 0..STEP positions of the selected
// operation to a value. Codes outside the defined set pass the value through.
module shift_step
   import shift_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int STEP  = 1,
   localparam int N_W   = $clog2(STEP + 1)
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] value,
   input  logic [N_W-1:0]   n,
   output logic [WIDTH-1:0] shifted
);

   // Wide enough to hold WIDTH itself, so the complementary rotate shift
   // for n=0 becomes a full-width shift that yields zero.
   localparam int SH_W = $clog2(WIDTH) + 1;

   logic [SH_W-1:0] n_ext;
   logic [SH_W-1:0] n_back;

   // Select and apply the requested operation for this cycle.
   always_comb begin
      n_ext   = SH_W'(n);
      n_back  = SH_W'(WIDTH) - n_ext;
      shifted = value;
      case (op)
         OP_SHR:  shifted = value >> n_ext;
         OP_SHRA: shifted = WIDTH'($signed(value) >>> n_ext);
         OP_SHL:  shifted = value << n_ext;
         OP_ROR:  shifted = (value >> n_ext) | (value << n_back);
         OP_ROL:  shifted = (value << n_ext) | (value >> n_back);
         default: shifted = value;
      endcase
   end

endmodule

// File: rtl/seq_shift_rotate_unit.sv
// Multi-cycle shift/rotate unit. The operand is captured on start and then
// moved up to STEP positions per clock until the requested count is used up.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; result holds the last final value
// ST_SHIFT | applying STEP (or the remainder) positions each clock
// ST_DONE  | one-cycle completion, done=1, result is final
module seq_shift_rotate_unit
   import shift_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int STEP  = 1,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             Clock,
   input  logic             clear,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AMT_W-1:0] amount,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done
);

   localparam int             N_W    = $clog2(STEP + 1);
   // One extra bit so STEP=WIDTH still compares correctly against the count.
   localparam logic [AMT_W:0] STEP_V = (AMT_W + 1)'(STEP);

   state_e           state;
   logic [2:0]       op_q;
   logic [AMT_W-1:0] remaining;

   logic [AMT_W:0]   rem_ext;
   logic             last_step;
   logic [N_W-1:0]   n_cur;
   logic [AMT_W-1:0] rem_next;
   logic [WIDTH-1:0] stepped;

   // Down-counter terminal check and the number of positions for this cycle.
   always_comb begin
      rem_ext   = {1'b0, remaining};
      last_step = (rem_ext <= STEP_V);
      n_cur     = last_step ? N_W'(remaining) : N_W'(STEP);
      rem_next  = AMT_W'(rem_ext - STEP_V);
   end

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_shift_step (
      .op      (op_q),
      .value   (result),
      .n       (n_cur),
      .shifted (stepped)
   );

   // Controller, working register and remaining-count down-counter.
   always_ff @(posedge Clock) begin
      if (clear) begin
         state     <= ST_IDLE;
         result    <= '0;
         op_q      <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  result    <= data_in;
                  op_q      <= op;
                  remaining <= amount;
                  busy      <= 1'b1;
                  if (amount != '0) begin
                     state <= ST_SHIFT;
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               result <= stepped;
               if (last_step) begin
                  remaining <= '0;
                  state     <= ST_DONE;
                  done      <= 1'b1;
               end else begin
                  remaining <= rem_next;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_rotate_unit.sv
// Bench for seq_shift_rotate_unit: one instance with STEP=1 and one with
// STEP=4, both WIDTH=32, driven by directed and random operations and
// compared against an arithmetic reference model.
module tb_seq_shift_rotate_unit;

   logic        Clock = 1'b0;
   logic        clear_s [2];
   logic        start_s [2];
   logic [2:0]  op_s    [2];
   logic [31:0] data_s  [2];
   logic [4:0]  amt_s   [2];
   logic [31:0] res_s   [2];
   logic        busy_s  [2];
   logic        done_s  [2];

   int checks = 0;
   int passes = 0;

   always #5 Clock = ~Clock;

   seq_shift_rotate_unit #(.WIDTH(32), .STEP(1)) dut_s1 (
      .Clock   (Clock),
      .clear   (clear_s[0]),
      .start   (start_s[0]),
      .op      (op_s[0]),
      .data_in (data_s[0]),
      .amount  (amt_s[0]),
      .result  (res_s[0]),
      .busy    (busy_s[0]),
      .done    (done_s[0])
   );

   seq_shift_rotate_unit #(.WIDTH(32), .STEP(4)) dut_s4 (
      .Clock   (Clock),
      .clear   (clear_s[1]),
      .start   (start_s[1]),
      .op      (op_s[1]),
      .data_in (data_s[1]),
      .amount  (amt_s[1]),
      .result  (res_s[1]),
      .busy    (busy_s[1]),
      .done    (done_s[1])
   );

   // Reference: the whole shift done at once with plain operators.
   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] v, input int n);
      logic [63:0] dbl;
      dbl = {v, v};
      case (o)
         3'd0: return v >> n;
         3'd1: return 32'($signed(v) >>> n);
         3'd2: return v << n;
         3'd3: begin dbl = dbl >> n; return dbl[31:0]; end
         3'd4: begin dbl = dbl << n; return dbl[63:32]; end
         default: return v;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Called at a negedge; returns at the negedge of the first IDLE cycle
   // after DONE, so consecutive calls issue back-to-back starts.
   task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] v,
                         input int amt, input logic [31:0] exp_res, input string tag);
      int step;
      int exp_lat;
      int k;
      step    = (d == 0) ? 1 : 4;
      exp_lat = (amt + step - 1) / step;
      start_s[d] = 1'b1;
      op_s[d]    = o;
      data_s[d]  = v;
      amt_s[d]   = 5'(amt);
      @(negedge Clock);
      start_s[d] = 1'b0;
      data_s[d]  = $urandom;
      op_s[d]    = 3'($urandom_range(0, 7));
      amt_s[d]   = 5'($urandom_range(0, 31));
      if (exp_lat > 0) check({tag, " busy_shift"}, 32'(busy_s[d]), 32'd1);
      k = 0;
      while (!done_s[d] && k < 40) begin
         @(negedge Clock);
         k++;
      end
      check({tag, " latency"}, 32'(k), 32'(exp_lat));
      check({tag, " result"}, res_s[d], exp_res);
      check({tag, " busy_done"}, 32'(busy_s[d]), 32'd1);
      @(negedge Clock);
      check({tag, " done_pulse"}, 32'(done_s[d]), 32'd0);
      check({tag, " busy_idle"}, 32'(busy_s[d]), 32'd0);
      check({tag, " result_hold"}, res_s[d], exp_res);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] rv;
      int          ra;
      for (int d = 0; d < 2; d++) begin
         clear_s[d] = 1'b1;
         start_s[d] = 1'b0;
         op_s[d]    = 3'd0;
         data_s[d]  = 32'd0;
         amt_s[d]   = 5'd0;
      end
      @(negedge Clock);
      @(negedge Clock);
      for (int d = 0; d < 2; d++) begin
         check("reset result", res_s[d], 32'd0);
         check("reset busy", 32'(busy_s[d]), 32'd0);
         check("reset done", 32'(done_s[d]), 32'd0);
         clear_s[d] = 1'b0;
      end
      @(negedge Clock);

      // Directed cases, STEP=1.
      run_op(0, 3'd4, 32'h8000_0001, 4, 32'h0000_0018, "rol4_s1");
      run_op(0, 3'd1, 32'hF000_0000, 4, 32'hFF00_0000, "shra4_s1");
      run_op(0, 3'd0, 32'hF000_0000, 4, 32'h0F00_0000, "shr4_s1");
      run_op(0, 3'd2, 32'h0000_0022, 1, 32'h0000_0044, "shl1_s1");
      run_op(0, 3'd3, 32'h1234_5678, 0, 32'h1234_5678, "ror0_s1");
      run_op(0, 3'd6, 32'hA5A5_0F0F, 7, 32'hA5A5_0F0F, "pass7_s1");

      // Directed cases, STEP=4.
      run_op(1, 3'd0, 32'h8000_0000, 31, 32'h0000_0001, "shr31_s4");
      run_op(1, 3'd3, 32'h0000_0001, 1, 32'h8000_0000, "ror1_s4");
      run_op(1, 3'd1, 32'h1234_5678, 0, 32'h1234_5678, "shra0_s4");
      run_op(1, 3'd4, 32'h8000_0001, 5, 32'h0000_0030, "rol5_s4");
      run_op(1, 3'd1, 32'h8000_0000, 31, 32'hFFFF_FFFF, "shra31_s4");

      // Start ignored while busy, then clear in the middle of SHIFT.
      start_s[0] = 1'b1; op_s[0] = 3'd4; data_s[0] = 32'h0000_0F01; amt_s[0] = 5'd10;
      @(negedge Clock);
      start_s[0] = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      start_s[0] = 1'b1; op_s[0] = 3'd2; data_s[0] = 32'hDEAD_BEEF; amt_s[0] = 5'd2;
      @(negedge Clock);
      start_s[0] = 1'b0;
      check("midshift result3", res_s[0], model(3'd4, 32'h0000_0F01, 3));
      @(negedge Clock);
      check("midshift result4", res_s[0], model(3'd4, 32'h0000_0F01, 4));
      check("midshift busy", 32'(busy_s[0]), 32'd1);
      clear_s[0] = 1'b1;
      @(negedge Clock);
      clear_s[0] = 1'b0;
      check("clear result", res_s[0], 32'd0);
      check("clear busy", 32'(busy_s[0]), 32'd0);
      check("clear done", 32'(done_s[0]), 32'd0);
      for (int i = 0; i < 8; i++) @(negedge Clock);
      check("clear stays idle", 32'({busy_s[0], done_s[0]}), 32'd0);
      run_op(0, 3'd4, 32'h0000_0001, 1, 32'h0000_0002, "rol1_after_clear");

      // Clear wins over a simultaneous start.
      start_s[1] = 1'b1; clear_s[1] = 1'b1; op_s[1] = 3'd0;
      data_s[1] = 32'h5555_AAAA; amt_s[1] = 5'd0;
      @(negedge Clock);
      start_s[1] = 1'b0; clear_s[1] = 1'b0;
      check("clear_vs_start busy", 32'(busy_s[1]), 32'd0);
      check("clear_vs_start done", 32'(done_s[1]), 32'd0);
      check("clear_vs_start result", res_s[1], 32'd0);

      // Random operations against the reference model.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom_range(0, 7));
            rv = $urandom;
            ra = int'($urandom_range(0, 31));
            run_op(d, ro, rv, ra, model(ro, rv, ra), $sformatf("rand_d%0d_op%0d_n%0d", d, ro, ra));
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
